// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and frame constants shared by the UART receiver and transmitter
package uart_pkg;
    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int DATA_BITS = 8;
    localparam logic STOP_LEVEL = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input, resetting to RST_VAL
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver sampling each bit at its centre, with frame-error and break handling
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int HALF_BIT = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    logic rx_s;
    state_e state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, ferr_q, ferr_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 16'd1;
        idx_d = idx_q;
        shift_d = shift_q;
        data_d = data_q;
        valid_d = 1'b0;
        ferr_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) state_d = START;
            end
            START: if (timer_q == HALF_END) begin
                timer_d = '0;
                idx_d = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (timer_q == BIT_END) begin
                timer_d = '0;
                shift_d[idx_q] = rx_s;
                idx_d = idx_q + 3'd1;
                if (idx_q == LAST_IDX) state_d = STOP;
            end
            STOP: if (timer_q == BIT_END) begin
                timer_d = '0;
                if (rx_s == STOP_LEVEL) begin
                    data_d = shift_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    ferr_d = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            // a held-low line reports one frame error, then waits for idle
            WAIT_IDLE: begin
                timer_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q <= '0;
            shift_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            data_q <= data_d;
            valid_q <= valid_d;
            ferr_q <= ferr_d;
        end
    end

    assign data = data_q;
    assign valid = valid_q;
    assign frame_err = ferr_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: scoreboard bench for uart_recv at 16 clocks per bit
module tb_uart_recv;
    typedef struct packed {
        logic err;
        logic [7:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic [7:0] data;
    logic valid, frame_err, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int vt[$];

    uart_recv #(.CLKS_PER_BIT(16), .HALF_BIT(8)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drives one frame for ncyc cycles; data bits and stop shifted late by skew cycles
    task automatic send_frame(input logic [7:0] b, input logic stop, input int skew, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int k;
            k = (c - skew) / 16;
            if (c < 16 + skew) rx = 1'b0;
            else if (k <= 8) rx = b[k-1];
            else rx = stop;
            tick(1);
        end
        rx = 1'b1;
    endtask

    task automatic monitor();
        logic prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (valid || frame_err) begin
                n_cmp++;
                if (valid && frame_err) begin
                    n_err++;
                    $display("FAIL both_pulses: valid=%b frame_err=%b, required not both", valid, frame_err);
                end
                n_cmp++;
                if (valid && prev_valid) begin
                    n_err++;
                    $display("FAIL valid_width: valid high 2 cycles, required 1");
                end
                if (valid) vt.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=%h, required none", valid, frame_err, data);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (frame_err !== e.err || (!e.err && data !== e.b)) begin
                        n_err++;
                        $display("FAIL scoreboard: frame_err=%b data=%h, required frame_err=%b data=%h", frame_err, data, e.err, e.b);
                    end
                end
            end
            prev_valid = valid;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        tick(3);
        n_cmp++;
        if ({data, valid, frame_err, busy} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_state: data=%h valid=%b ferr=%b busy=%b, required 00 0 0 0", data, valid, frame_err, busy);
        end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_single();
        exp_q.push_back(exp_t'({1'b0, 8'h41}));
        send_frame(8'h41, 1'b1, 0, 160);
        drain(40);
        n_cmp++;
        if (data !== 8'h41 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_frame: data=%h busy=%b, required 41 0", data, busy);
        end
    endtask

    task automatic test_back_to_back();
        vt.delete();
        exp_q.push_back(exp_t'({1'b0, 8'h00}));
        exp_q.push_back(exp_t'({1'b0, 8'hFF}));
        send_frame(8'h00, 1'b1, 0, 160);
        send_frame(8'hFF, 1'b1, 0, 160);
        drain(40);
        n_cmp++;
        if (vt.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: %0d valid pulses, required 2", vt.size());
        end else begin
            n_cmp++;
            if (vt[1] - vt[0] != 160) begin
                n_err++;
                $display("FAIL b2b_spacing: %0d cycles, required 160", vt[1] - vt[0]);
            end
        end
        n_cmp++;
        if (data !== 8'hFF) begin
            n_err++;
            $display("FAIL b2b_data: data=%h, required ff", data);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d0;
        d0 = data;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        n_cmp++;
        if (busy !== 1'b0 || data !== d0) begin
            n_err++;
            $display("FAIL glitch: busy=%b data=%h, required 0 %h", busy, data, d0);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] d0;
        d0 = data;
        exp_q.push_back(exp_t'({1'b1, 8'h00}));
        send_frame(8'hA5, 1'b0, 0, 160);
        rx = 1'b0;
        tick(40);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ferr_pulse: %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        n_cmp++;
        if (busy !== 1'b1 || data !== d0) begin
            n_err++;
            $display("FAIL ferr_hold: busy=%b data=%h, required 1 %h", busy, data, d0);
        end
        rx = 1'b1;
        tick(6);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL ferr_release: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h3C, 1'b1, 0, 72);
        rx = 1'b1;
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if ({data, valid, frame_err, busy} !== 11'h0) begin
            n_err++;
            $display("FAIL mid_reset: data=%h valid=%b ferr=%b busy=%b, required 00 0 0 0", data, valid, frame_err, busy);
        end
        rst = 1'b0;
        tick(20);
        exp_q.push_back(exp_t'({1'b0, 8'h5A}));
        send_frame(8'h5A, 1'b1, 0, 160);
        drain(40);
        n_cmp++;
        if (data !== 8'h5A) begin
            n_err++;
            $display("FAIL after_reset: data=%h, required 5a", data);
        end
    endtask

    task automatic test_skew();
        exp_q.push_back(exp_t'({1'b0, 8'h81}));
        send_frame(8'h81, 1'b1, 5, 165);
        drain(40);
        n_cmp++;
        if (data !== 8'h81) begin
            n_err++;
            $display("FAIL skewed_frame: data=%h, required 81", data);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_skew();
        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
